ctrl_sequencer: RTL and testbench
=================================

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 Parameter PC_W, default 10, program-counter width.
REQ-002 Parameter LAST_PC, default 10'h3FF, address of the final instruction.
REQ-003 Parameter INSTR_W, fixed at 9: bits [8:6] opcode, [5:3] rs1/rd, [2:0] rs2.
REQ-004 clk  in  1  the single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle pulse that starts the program at PC 0.
REQ-007 imem_req / imem_addr  out  1 / PC_W  instruction-fetch request and address.
REQ-008 imem_valid / imem_data  in  1 / 9  fetch complete and the instruction word.
REQ-009 alu_op  out  3  ALU opcode, equal to IR[8:6] while in EXEC or MEM, 0 otherwise.
REQ-010 rs1_addr / rs2_addr / rd_addr  out  3 each  register addresses; rs1_addr = rd_addr = IR[5:3], rs2_addr = IR[2:0].
REQ-011 rf_we  out  1  register-file write strobe.
REQ-012 jump_flag  in  1  ALU branch-compare result.
REQ-013 br_target  in  8  branch target, zero-extended to PC_W.
REQ-014 dmem_req / dmem_we  out  1 / 1  data-memory request and write enable.
REQ-015 dmem_ready  in  1  data-memory access complete.
REQ-016 busy / done  out  1 / 1  program running / program finished.

Function
REQ-017 Opcode encoding: ADD=0, XOR=1, AND=2, RSL=3, MOV=4, LD=5, ST=6, BLQZ=7.
REQ-018 The FSM states are IDLE, FETCH, EXEC, MEM and DONE; the FSM is Moore except for the rf_we and dmem handshake terms defined below.
REQ-019 IDLE: outputs are inactive; start=1 sets PC to 0 and moves to FETCH.
REQ-020 FETCH: imem_req=1 and imem_addr=PC are held until imem_valid=1; on that edge IR latches imem_data and the FSM moves to EXEC.
REQ-021 EXEC, opcodes 0-4: alu_op is driven, rf_we=1 for exactly this one cycle, and PC advances to PC+1 (wrapping modulo 2^PC_W).
REQ-022 EXEC, LD or ST: no write occurs and the FSM moves to MEM.
REQ-023 MEM: dmem_req=1 and dmem_we=(op==ST) are held until dmem_ready=1.
REQ-024 MEM completion: in the dmem_ready cycle, rf_we=(op==LD) and PC advances to PC+1.
REQ-025 EXEC, BLQZ: rf_we=0; PC is set to br_target if jump_flag=1, otherwise to PC+1; jump_flag is sampled only in this cycle.
REQ-026 When the instruction just retired was at PC==LAST_PC and it was not a taken branch, the next state is DONE; otherwise the next state is FETCH.
REQ-027 DONE: done=1 and busy=0; start=1 restarts at PC 0 in FETCH.
REQ-028 busy=1 in FETCH, EXEC and MEM, and 0 otherwise.
REQ-029 start is ignored while busy=1.
REQ-030 imem_valid is ignored outside FETCH, and dmem_ready is ignored outside MEM.
REQ-031 A taken branch to the current PC is legal and loops indefinitely.
REQ-032 Illegal FSM state encodings recover to IDLE on the next clock.

Reset
REQ-033 While rst_n=0, independent of clk, the sequencer shall enter IDLE with PC=0, IR=0, and all outputs 0.
REQ-034 Reset asserted in any state, including mid-fetch or mid-MEM, shall abandon the operation; no rf_we or dmem_req pulse shall occur after the reset edge.
REQ-035 After rst_n deasserts, the sequencer shall remain in IDLE until start=1.

Verification
REQ-036 Straight-line run: LAST_PC=2, program ADD, XOR, MOV, imem_valid one cycle after each request -> three single-cycle rf_we pulses, PC sequence 0,1,2, then done=1.
REQ-037 Memory stall: LD, with dmem_ready delayed 4 cycles -> dmem_req high for 5 cycles with dmem_we=0, and rf_we=1 only in the dmem_ready cycle.
REQ-038 ST: ST instruction -> dmem_we=1 throughout MEM and rf_we stays 0.
REQ-039 Branch both ways: BLQZ at PC 5, br_target=8'h20; with jump_flag=1 -> next imem_addr=0x020; with jump_flag=0 -> next imem_addr=0x006.
REQ-040 Reset mid-operation: rst_n pulled low during a MEM stall -> outputs are 0 immediately; after release the sequencer stays in IDLE, and start restarts the fetch at imem_addr=0.
REQ-041 Ignored start: start pulsed while busy=1 -> PC and state are unaffected; start pulsed in DONE -> fetch at 0 and done falls.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle fetch/execute sequencer for a 9-bit, 8-opcode instruction set.
// Runs IDLE -> FETCH -> EXEC [-> MEM] repeatedly until the instruction at LAST_PC retires.
module ctrl_sequencer #(
  parameter int unsigned     PC_W    = 10,
  parameter logic [PC_W-1:0] LAST_PC = 10'h3FF,
  parameter int unsigned     INSTR_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [2:0]         alu_op,
  output logic [2:0]         rs1_addr,
  output logic [2:0]         rs2_addr,
  output logic [2:0]         rd_addr,
  output logic               rf_we,
  input  logic               jump_flag,
  input  logic [7:0]         br_target,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ready,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_XOR  = 3'd1,
    OP_AND  = 3'd2,
    OP_RSL  = 3'd3,
    OP_MOV  = 3'd4,
    OP_LD   = 3'd5,
    OP_ST   = 3'd6,
    OP_BLQZ = 3'd7
  } opcode_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;

  opcode_e              op;
  logic [PC_W-1:0]      pc_inc;
  state_e               retire_st;

  assign op        = opcode_e'(ir_q[8:6]);
  assign pc_inc    = pc_q + PC_W'(1);
  // A non-branching retirement at LAST_PC ends the program; taken branches never do.
  assign retire_st = (pc_q == LAST_PC) ? S_DONE : S_FETCH;

  assign rs1_addr = ir_q[5:3];
  assign rd_addr  = ir_q[5:3];
  assign rs2_addr = ir_q[2:0];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    imem_req  = 1'b0;
    imem_addr = '0;
    alu_op    = '0;
    rf_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        busy      = 1'b1;
        imem_req  = 1'b1;
        imem_addr = pc_q;
        if (imem_valid) begin
          ir_d    = imem_data;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        busy   = 1'b1;
        alu_op = op;
        case (op)
          OP_LD, OP_ST: state_d = S_MEM;
          OP_BLQZ: begin
            if (jump_flag) begin
              pc_d    = PC_W'(br_target);
              state_d = S_FETCH;
            end else begin
              pc_d    = pc_inc;
              state_d = retire_st;
            end
          end
          default: begin
            rf_we   = 1'b1;
            pc_d    = pc_inc;
            state_d = retire_st;
          end
        endcase
      end

      S_MEM: begin
        busy     = 1'b1;
        alu_op   = op;
        dmem_req = 1'b1;
        dmem_we  = (op == OP_ST);
        if (dmem_ready) begin
          rf_we   = (op == OP_LD);
          pc_d    = pc_inc;
          state_d = retire_st;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: instruction-level reference model compared every cycle,
// plus literal checks on fetch order, write pulses, memory handshakes and reset behaviour.
module tb_ctrl_sequencer;

  localparam int unsigned PC_W = 10;
  localparam logic [9:0]  LAST = 10'd2;

  logic       clk, rst_n, start;
  logic       imem_req, imem_valid;
  logic [9:0] imem_addr;
  logic [8:0] imem_data;
  logic [2:0] alu_op, rs1_addr, rs2_addr, rd_addr;
  logic       rf_we, jump_flag, dmem_req, dmem_we, dmem_ready, busy, done;
  logic [7:0] br_target;

  ctrl_sequencer #(.PC_W(PC_W), .LAST_PC(LAST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .alu_op(alu_op), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rf_we(rf_we), .jump_flag(jump_flag), .br_target(br_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] mk(input int op, input int a, input int b);
    return {3'(op), 3'(a), 3'(b)};
  endfunction

  // ---------------- stimulus memories / responders ----------------
  logic [8:0] prog [0:63];
  logic [8:0] br_q [$];
  int   ilat = 1, ld_lat = 4, st_lat = 2;
  int   icnt = 0, dcnt = 0;
  int   last_op = 0;
  bit   noise = 1'b0, br_pending = 1'b0;

  initial begin
    imem_valid = 1'b0; imem_data = '0; dmem_ready = 1'b0;
    jump_flag = 1'b0; br_target = '0;
    forever begin
      @(posedge clk); #1;
      noise = ~noise;
      if (!rst_n) begin
        imem_valid = 1'b0; dmem_ready = 1'b0; jump_flag = 1'b0;
        icnt = 0; dcnt = 0; br_pending = 1'b0;
      end else begin
        // Branch operands are real only in the BLQZ execute cycle; noise elsewhere.
        if (br_pending) begin
          if (br_q.size() > 0) {jump_flag, br_target} = br_q.pop_front();
          else {jump_flag, br_target} = 9'h0;
          br_pending = 1'b0;
        end else begin
          jump_flag = noise; br_target = 8'hEE;
        end
        if (imem_req) begin
          if (icnt >= ilat) begin
            imem_valid = 1'b1; imem_data = prog[imem_addr[5:0]];
            last_op = int'(imem_data[8:6]); br_pending = (imem_data[8:6] == 3'd7); icnt = 0;
          end else begin
            imem_valid = 1'b0; imem_data = 9'h1FF; icnt++;
          end
        end else begin
          imem_valid = noise; imem_data = 9'h1FF; icnt = 0;
        end
        if (dmem_req) begin
          if (dcnt >= ((last_op == 5) ? ld_lat : st_lat)) begin
            dmem_ready = 1'b1; dcnt = 0;
          end else begin
            dmem_ready = 1'b0; dcnt++;
          end
        end else begin
          dmem_ready = noise; dcnt = 0;
        end
      end
    end
  end

  // ---------------- instruction-level reference model ----------------
  typedef enum {M_OFF, M_FETCH, M_DECODE, M_ACCESS, M_FIN} mstage_e;
  mstage_e    m_st = M_OFF;
  int         m_pc = 0;
  logic [8:0] m_ir = '0;
  int         m_op, m_next;
  bit         m_taken;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = M_OFF; m_pc = 0; m_ir = '0;
    end else begin
      m_op = int'(m_ir[8:6]);
      case (m_st)
        M_OFF, M_FIN: if (start) begin m_pc = 0; m_st = M_FETCH; end
        M_FETCH: if (imem_valid) begin m_ir = imem_data; m_st = M_DECODE; end
        M_DECODE, M_ACCESS: begin
          if (m_st == M_DECODE && (m_op == 5 || m_op == 6)) m_st = M_ACCESS;
          else if (m_st == M_DECODE || dmem_ready) begin
            m_taken = (m_st == M_DECODE) && (m_op == 7) && jump_flag;
            m_next  = m_taken ? int'(br_target) : (m_pc + 1) % 1024;
            m_st    = (m_pc == int'(LAST) && !m_taken) ? M_FIN : M_FETCH;
            m_pc    = m_next;
          end
        end
        default: m_st = M_OFF;
      endcase
    end
  end

  // ---------------- per-cycle compare and event logs ----------------
  int   fetch_log [$];
  int   rfwe_cnt, ld_req_cnt, dwe_cnt, rfwe_mem_cnt, rfwe_st_cnt;
  logic [27:0] cmp_act, cmp_exp;
  int   c_op;
  bit   c_fetch, c_exec, c_mem, c_we;

  always @(negedge clk) begin
    c_op    = int'(m_ir[8:6]);
    c_fetch = (m_st == M_FETCH);
    c_exec  = (m_st == M_DECODE);
    c_mem   = (m_st == M_ACCESS);
    c_we    = (c_exec && c_op <= 4) || (c_mem && c_op == 5 && dmem_ready);
    cmp_exp = {c_fetch, c_fetch ? 10'(m_pc) : 10'h0, (c_exec || c_mem) ? 3'(c_op) : 3'd0,
               m_ir[5:3], m_ir[2:0], m_ir[5:3], c_we, c_mem, c_mem && c_op == 6,
               c_fetch || c_exec || c_mem, m_st == M_FIN};
    cmp_act = {imem_req, c_fetch ? imem_addr : 10'h0, alu_op, rs1_addr, rs2_addr, rd_addr,
               rf_we, dmem_req, dmem_we, busy, done};
    chk("cycle_outputs", 64'(cmp_act), 64'(cmp_exp));
    if (imem_req && imem_valid) fetch_log.push_back(int'(imem_addr));
    if (rf_we) rfwe_cnt++;
    if (dmem_req && !dmem_we) ld_req_cnt++;
    if (dmem_we) dwe_cnt++;
    if (rf_we && dmem_req) rfwe_mem_cnt++;
    if (rf_we && dmem_we) rfwe_st_cnt++;
  end

  task automatic clear_logs();
    fetch_log.delete();
    rfwe_cnt = 0; ld_req_cnt = 0; dwe_cnt = 0; rfwe_mem_cnt = 0; rfwe_st_cnt = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_until_done(input int maxc, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({nm, "_done"}, 64'(seen), 64'd1);
  endtask

  task automatic chk_fetch_seq(input string nm, input int exp_seq [$]);
    chk({nm, "_len"}, 64'(fetch_log.size()), 64'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < fetch_log.size(); i++)
      chk($sformatf("%s[%0d]", nm, i), 64'(fetch_log[i]), 64'(exp_seq[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    bit seen;
    start = 1'b0;
    for (int i = 0; i < 64; i++) prog[i] = 9'h000;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'({imem_req, imem_addr, alu_op, rs1_addr, rs2_addr, rd_addr,
                              rf_we, dmem_req, dmem_we, busy, done}), 64'd0);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_holds_without_start", 64'({busy, done, imem_req}), 64'd0);

    // Straight line: ADD, XOR, MOV, ending at LAST_PC=2.
    prog[0] = mk(0, 1, 2); prog[1] = mk(1, 3, 4); prog[2] = mk(4, 5, 6);
    clear_logs();
    pulse_start();
    run_until_done(100, "straight");
    chk_fetch_seq("straight_fetch", '{0, 1, 2});
    chk("straight_rf_we_pulses", 64'(rfwe_cnt), 64'd3);
    chk("straight_done_state", 64'({done, busy}), 64'b10);

    // LD with 4-cycle stall, then ST with 2-cycle stall, then AND; restart from DONE.
    prog[0] = mk(5, 2, 1); prog[1] = mk(6, 4, 5); prog[2] = mk(2, 7, 0);
    ld_lat = 4; st_lat = 2;
    clear_logs();
    pulse_start();
    @(negedge clk);
    chk("restart_from_done", 64'({done, imem_req, imem_addr}), 64'({1'b0, 1'b1, 10'h000}));
    run_until_done(200, "mem");
    chk("ld_dmem_req_cycles", 64'(ld_req_cnt), 64'd5);
    chk("st_dmem_we_cycles", 64'(dwe_cnt), 64'd3);
    chk("ld_rf_we_in_mem", 64'(rfwe_mem_cnt), 64'd1);
    chk("st_no_rf_we", 64'(rfwe_st_cnt), 64'd0);
    chk("mem_rf_we_total", 64'(rfwe_cnt), 64'd2);

    // Branches: taken/not-taken at PC 5, self-loop at LAST_PC, stray start while busy.
    for (int i = 0; i < 64; i++) prog[i] = mk(7, 1, 2);
    br_q.delete();
    br_q.push_back(9'h105); br_q.push_back(9'h120); br_q.push_back(9'h105);
    br_q.push_back(9'h000); br_q.push_back(9'h102); br_q.push_back(9'h102);
    br_q.push_back(9'h102); br_q.push_back(9'h000);
    clear_logs();
    pulse_start();
    repeat (6) @(posedge clk);
    pulse_start();
    run_until_done(300, "branch");
    chk_fetch_seq("branch_fetch", '{0, 5, 32, 5, 6, 2, 2, 2});
    chk("branch_no_rf_we", 64'(rfwe_cnt), 64'd0);

    // Reset during a long MEM stall.
    prog[0] = mk(5, 3, 3); prog[1] = mk(0, 1, 1); prog[2] = mk(3, 2, 2);
    ld_lat = 50;
    clear_logs();
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (dmem_req) seen = 1'b1;
    end
    chk("reach_mem_stall", 64'(seen), 64'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset_async_outputs", 64'({imem_req, imem_addr, alu_op, rs1_addr, rs2_addr, rd_addr,
                                     rf_we, dmem_req, dmem_we, busy, done}), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    clear_logs();
    repeat (4) @(negedge clk);
    chk("idle_after_reset", 64'({busy, done, imem_req, dmem_req}), 64'd0);
    chk("no_pulses_after_reset", 64'(rfwe_cnt + ld_req_cnt), 64'd0);
    ld_lat = 1;
    pulse_start();
    @(negedge clk);
    chk("restart_fetch0", 64'({imem_req, imem_addr}), 64'({1'b1, 10'h000}));
    run_until_done(100, "post_reset");
    chk("post_reset_rf_we", 64'(rfwe_cnt), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
